// File: rtl/reg_access_unit_if.sv
// Bus between the datapath/control side, the register file and the
// register access unit. The unit itself connects through the slave
// modport. The master modport is the datapath/control view.
interface reg_access_unit_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   // Handshakes: start is a one-cycle request that is accepted only while
   // the unit is idle; busy=0 acts as its ready. wb_valid is accepted only
   // while operands_valid=1 (the HOLD phase), which acts as its ready.
   // Requests made while the matching ready is low are dropped, not queued.
   logic              start;
   logic [31:0]       instr;
   logic              wb_sel_rd;
   logic              wb_valid;
   logic              wb_en;
   logic [DATA_W-1:0] wb_data;
   logic [DATA_W-1:0] rf_rd1;
   logic [DATA_W-1:0] rf_rd2;
   logic [ADDR_W-1:0] rf_a1;
   logic [ADDR_W-1:0] rf_a2;
   logic [ADDR_W-1:0] rf_wa3;
   logic [DATA_W-1:0] rf_wd3;
   logic              rf_we3;
   logic [DATA_W-1:0] a_reg;
   logic [DATA_W-1:0] b_reg;
   logic              operands_valid;
   logic              busy;
   logic              wb_done;

   modport master (
      output start, instr, wb_sel_rd, wb_valid, wb_en, wb_data, rf_rd1, rf_rd2,
      input  rf_a1, rf_a2, rf_wa3, rf_wd3, rf_we3, a_reg, b_reg,
             operands_valid, busy, wb_done
   );

   modport slave (
      input  start, instr, wb_sel_rd, wb_valid, wb_en, wb_data, rf_rd1, rf_rd2,
      output rf_a1, rf_a2, rf_wa3, rf_wd3, rf_we3, a_reg, b_reg,
             operands_valid, busy, wb_done
   );
endinterface

// File: rtl/reg_access_unit.sv
// Register access unit: captures an instruction's register fields, fetches
// both operands from the register file into A/B holding registers, and
// later performs the single write-back. Only this block drives rf_we3.
module reg_access_unit #(
   parameter int DATA_W        = 32,
   parameter int ADDR_W        = 5,
   parameter bit ZERO_WRITABLE = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   reg_access_unit_if.slave bus,
   output logic [2:0]       dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_HOLD  = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] rs_q;
   logic [ADDR_W-1:0] rt_q;
   logic [ADDR_W-1:0] dest_q;
   logic [DATA_W-1:0] wd_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic              we_q;
   logic              ov_q;
   logic              busy_q;
   logic              done_q;

   // Opcode, shamt and funct bits are not used by this unit.
   logic unused_instr_bits;
   assign unused_instr_bits = ^{bus.instr[31:26], bus.instr[10:0]};

   // A write to register 0 is dropped unless the parameter allows it.
   logic dest_writable;
   assign dest_writable = (dest_q != '0) || ZERO_WRITABLE;

   // Control FSM; every output is registered and set for the state being entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         rs_q   <= '0;
         rt_q   <= '0;
         dest_q <= '0;
         wd_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         we_q   <= 1'b0;
         ov_q   <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  rs_q   <= bus.instr[25:21];
                  rt_q   <= bus.instr[20:16];
                  dest_q <= bus.wb_sel_rd ? bus.instr[15:11] : bus.instr[20:16];
                  busy_q <= 1'b1;
                  state  <= S_READ;
               end
            end
            S_READ: begin
               // Read addresses have been stable for the whole cycle here.
               a_q   <= bus.rf_rd1;
               b_q   <= bus.rf_rd2;
               ov_q  <= 1'b1;
               state <= S_HOLD;
            end
            S_HOLD: begin
               if (bus.wb_valid) begin
                  ov_q <= 1'b0;
                  if (bus.wb_en && dest_writable) begin
                     wd_q  <= bus.wb_data;
                     we_q  <= 1'b1;
                     state <= S_WRITE;
                  end else begin
                     done_q <= 1'b1;
                     state  <= S_DONE;
                  end
               end
            end
            S_WRITE: begin
               we_q   <= 1'b0;
               done_q <= 1'b1;
               state  <= S_DONE;
            end
            S_DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
            default: begin
               we_q   <= 1'b0;
               ov_q   <= 1'b0;
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.rf_a1          = rs_q;
   assign bus.rf_a2          = rt_q;
   assign bus.rf_wa3         = dest_q;
   assign bus.rf_wd3         = wd_q;
   assign bus.rf_we3         = we_q;
   assign bus.a_reg          = a_q;
   assign bus.b_reg          = b_q;
   assign bus.operands_valid = ov_q;
   assign bus.busy           = busy_q;
   assign bus.wb_done        = done_q;
   assign dbg_state          = state;

endmodule
